// File: rtl/sprite_animator_if.sv
// Memory-side bus of the sprite animator: sprite ROM address/data and the
// palette lookup (index out, RGB back). The sprite drives the master side;
// the ROM and palette sit on the slave side.
interface sprite_animator_if #(
  parameter int ADDR_W = 11,
  parameter int IDX_W  = 4
);
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data;
  logic [IDX_W-1:0]  pal_idx;
  logic [3:0]        pal_r;
  logic [3:0]        pal_g;
  logic [3:0]        pal_b;

  modport master (
    output rom_addr,
    output pal_idx,
    input  rom_data,
    input  pal_r,
    input  pal_g,
    input  pal_b
  );

  modport slave (
    input  rom_addr,
    input  pal_idx,
    output rom_data,
    output pal_r,
    output pal_g,
    output pal_b
  );
endinterface

// File: rtl/sprite_animator.sv
// sprite_animator: animated sprite layer for the video path.
// Latches the sprite position once per video frame, addresses a multi-frame
// sprite ROM from the beam position, drops transparent pixels and registers
// RGB + active for the layer compositor (2-cycle pixel latency). An
// IDLE/PLAY/DONE sequencer steps animation frames every ANIM_DIV frame_ticks.
// Optional feature macro: SPRITE_FLIP_EN (adds flip_h, horizontal mirroring).
module sprite_animator #(
  parameter int CHAR_W     = 20,
  parameter int CHAR_H     = 20,
  parameter int NUM_FRAMES = 4,
  parameter int ANIM_DIV   = 8,
  parameter int IDX_W      = 4,
  parameter int ADDR_W     = 11,
  parameter int TRANSP_IDX = 0,
  localparam int FRAME_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [9:0]         CharX,
  input  logic [9:0]         CharY,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
`ifdef SPRITE_FLIP_EN
  input  logic               flip_h,
`endif
  sprite_animator_if.master  mem,
  output logic [3:0]         red_out,
  output logic [3:0]         green_out,
  output logic [3:0]         blue_out,
  output logic               active,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               busy,
  output logic               done
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [DIV_W-1:0]   div_q;
  logic               oneshot_q;
  logic               done_q;
  logic [FRAME_W-1:0] frame_step_d;

  logic [9:0]  pos_x_q;
  logic [9:0]  pos_y_q;
  logic        hit;
  logic        hit_q;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic [9:0]  sx_eff;
  logic [10:0] x_end;
  logic [10:0] y_end;

  logic [3:0]  red_q;
  logic [3:0]  green_q;
  logic [3:0]  blue_q;
  logic        active_q;

  // Latch the sprite position only at the frame boundary so a mid-frame
  // CharX/CharY change cannot tear the image.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (frame_tick) begin
      pos_x_q <= CharX;
      pos_y_q <= CharY;
    end
  end

  // Hit test in 11 bits so a box hanging past column/row 1023 does not wrap,
  // and the ROM address of the pixel under the beam.
  always_comb begin
    x_end  = {1'b0, pos_x_q} + 11'(CHAR_W);
    y_end  = {1'b0, pos_y_q} + 11'(CHAR_H);
    hit    = blank
          && ({1'b0, DrawX} >= {1'b0, pos_x_q}) && ({1'b0, DrawX} < x_end)
          && ({1'b0, DrawY} >= {1'b0, pos_y_q}) && ({1'b0, DrawY} < y_end);
    sx     = DrawX - pos_x_q;
    sy     = DrawY - pos_y_q;
    sx_eff = sx;
`ifdef SPRITE_FLIP_EN
    if (flip_h) begin
      sx_eff = 10'(CHAR_W - 1) - sx;
    end
`endif
    mem.rom_addr = ADDR_W'(frame_q) * ADDR_W'(CHAR_W * CHAR_H)
                 + ADDR_W'(sy) * ADDR_W'(CHAR_W)
                 + ADDR_W'(sx_eff);
  end

  assign mem.pal_idx = mem.rom_data;

  // Pixel pipeline: hit is delayed to line up with the synchronous ROM data,
  // then the palette colour is registered for opaque hits only.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q    <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      active_q <= 1'b0;
    end else begin
      hit_q <= hit;
      if (hit_q && (mem.rom_data != IDX_W'(TRANSP_IDX))) begin
        red_q    <= mem.pal_r;
        green_q  <= mem.pal_g;
        blue_q   <= mem.pal_b;
        active_q <= 1'b1;
      end else begin
        red_q    <= '0;
        green_q  <= '0;
        blue_q   <= '0;
        active_q <= 1'b0;
      end
    end
  end

  // Frame reached by the next animation step: loops wrap, a oneshot parks on
  // the last frame.
  always_comb begin
    if (frame_q == LAST_FRAME) begin
      frame_step_d = oneshot_q ? LAST_FRAME : '0;
    end else begin
      frame_step_d = frame_q + FRAME_W'(1);
    end
  end

  // Animation sequencer. stop beats start beats a frame_tick step. A oneshot
  // finishes as soon as a step lands on the last frame (for a single-frame
  // sprite that is the very first step).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      div_q     <= '0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= S_IDLE;
      end else if (start) begin
        state_q   <= S_PLAY;
        frame_q   <= '0;
        div_q     <= '0;
        oneshot_q <= oneshot;
      end else begin
        case (state_q)
          S_PLAY: begin
            if (frame_tick) begin
              if (div_q == DIV_LAST) begin
                div_q   <= '0;
                frame_q <= frame_step_d;
                if (oneshot_q && (frame_step_d == LAST_FRAME)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end else begin
                div_q <= div_q + DIV_W'(1);
              end
            end
          end
          S_DONE:  state_q <= S_DONE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign red_out    = red_q;
  assign green_out  = green_q;
  assign blue_out   = blue_q;
  assign active     = active_q;
  assign anim_frame = frame_q;
  assign busy       = (state_q == S_PLAY);
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench for sprite_animator: directed steps plus randomized
// pixel probes, checked against a frame/tick-count reference model.
module tb_sprite_animator;

  localparam int W   = 20;
  localparam int H   = 20;
  localparam int NF  = 4;
  localparam int DIV = 8;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, CharX, CharY;
  logic       blank, frame_tick, start, stop, oneshot;
`ifdef SPRITE_FLIP_EN
  logic       flip_h;
`endif
  logic [3:0] red_out, green_out, blue_out;
  logic       active, busy, done;
  logic [1:0] anim_frame;

  sprite_animator_if #(.ADDR_W(11), .IDX_W(4)) mem_if ();

  logic [3:0] rom [2048];
  logic [3:0] pr_tab [16];
  logic [3:0] pg_tab [16];
  logic [3:0] pb_tab [16];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_px = 0, m_py = 0, m_frame = 0, m_ticks = 0;
  bit m_play = 0, m_oneshot = 0;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) mem_if.rom_data <= rom[mem_if.rom_addr];
  assign mem_if.pal_r = pr_tab[mem_if.pal_idx];
  assign mem_if.pal_g = pg_tab[mem_if.pal_idx];
  assign mem_if.pal_b = pb_tab[mem_if.pal_idx];

  sprite_animator dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .CharX      (CharX),
    .CharY      (CharY),
    .blank      (blank),
    .frame_tick (frame_tick),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
`ifdef SPRITE_FLIP_EN
    .flip_h     (flip_h),
`endif
    .mem        (mem_if.master),
    .red_out    (red_out),
    .green_out  (green_out),
    .blue_out   (blue_out),
    .active     (active),
    .anim_frame (anim_frame),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge vga_clk);
    #1;
  endtask

  // Expected registered pixel for a beam position, from the sprite rules.
  task automatic model_pix(input int dx, input int dy, input bit blk, input bit flp,
                           output logic [11:0] rgb, output logic act);
    int sx, sy, addr;
    logic [3:0] idx;
    rgb = 12'h000;
    act = 1'b0;
    if (blk && dx >= m_px && dx < m_px + W && dy >= m_py && dy < m_py + H) begin
      sx = dx - m_px;
      sy = dy - m_py;
      if (flp) sx = W - 1 - sx;
      addr = (m_frame * W * H + sy * W + sx) % 2048;
      idx  = rom[addr];
      if (idx != 4'd0) begin
        rgb = {pr_tab[idx], pg_tab[idx], pb_tab[idx]};
        act = 1'b1;
      end
    end
  endtask

  task automatic probe(input string tag, input int dx, input int dy, input bit blk);
    logic [11:0] e_rgb;
    logic        e_act;
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    blank = blk;
    tick_clk();
    tick_clk();
    model_pix(dx, dy, blk, 1'b0, e_rgb, e_act);
    $display("pixel %s x=%0d y=%0d blank=%0d frame=%0d rgb=%03h active=%0d",
             tag, dx, dy, blk, m_frame, {red_out, green_out, blue_out}, active);
    check({tag, "_rgb"}, {20'd0, red_out, green_out, blue_out}, {20'd0, e_rgb});
    check({tag, "_act"}, {31'd0, active}, {31'd0, e_act});
  endtask

  task automatic pulse_tick(input string tag);
    int  steps;
    bit  e_done;
    e_done     = 1'b0;
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    m_px = int'(CharX);
    m_py = int'(CharY);
    if (m_play) begin
      m_ticks++;
      if (m_ticks % DIV == 0) begin
        steps = m_ticks / DIV;
        if (m_oneshot) begin
          m_frame = (steps >= NF - 1) ? NF - 1 : steps;
          if (steps >= NF - 1) begin
            e_done = 1'b1;
            m_play = 1'b0;
          end
        end else begin
          m_frame = steps % NF;
        end
      end
    end
    $display("tick %s n=%0d frame=%0d busy=%0d done=%0d", tag, m_ticks, anim_frame, busy, done);
    check({tag, "_frame"}, {30'd0, anim_frame}, 32'(m_frame));
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, m_play});
    check({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    tick_clk();
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_start(input bit os);
    start   = 1'b1;
    oneshot = os;
    tick_clk();
    start   = 1'b0;
    oneshot = 1'b0;
    m_play = 1'b1; m_ticks = 0; m_frame = 0; m_oneshot = os;
    $display("start oneshot=%0d frame=%0d busy=%0d", os, anim_frame, busy);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_frame", {30'd0, anim_frame}, 32'd0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick_clk();
    stop   = 1'b0;
    m_play = 1'b0;
    $display("stop frame=%0d busy=%0d", anim_frame, busy);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_frame", {30'd0, anim_frame}, 32'(m_frame));
  endtask

  initial begin
    int x, y;
    for (int i = 0; i < 2048; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    for (int i = 0; i < 16; i++) begin
      pr_tab[i] = 4'($urandom);
      pg_tab[i] = 4'($urandom);
      pb_tab[i] = 4'($urandom);
    end
    reset_n = 1'b0;
    DrawX = '0; DrawY = '0; CharX = '0; CharY = '0;
    blank = 1'b0; frame_tick = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
`ifdef SPRITE_FLIP_EN
    flip_h = 1'b0;
`endif
    repeat (3) tick_clk();
    $display("reset rgb=%03h active=%0d frame=%0d busy=%0d done=%0d",
             {red_out, green_out, blue_out}, active, anim_frame, busy, done);
    check("rst_rgb", {20'd0, red_out, green_out, blue_out}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_frame", {30'd0, anim_frame}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    tick_clk();

    // Static draw at (100,50)
    rom[45] = 4'd3;
    pr_tab[3] = 4'hF; pg_tab[3] = 4'h0; pb_tab[3] = 4'h0;
    rom[59] = 4'd5;
    CharX = 10'd100; CharY = 10'd50;
    pulse_tick("latch");
    DrawX = 10'd105; DrawY = 10'd52; blank = 1'b1;
    #1;
    check("static_addr", 32'(mem_if.rom_addr), 32'd45);
    probe("static", 105, 52, 1'b1);
    check("static_rgb_f00", {20'd0, red_out, green_out, blue_out}, 32'h0F00);
    probe("right_out", 120, 52, 1'b1);
    probe("right_in", 119, 52, 1'b1);
    check("right_in_act", {31'd0, active}, 32'd1);
    probe("blanked", 105, 52, 1'b0);
    rom[45] = 4'd0;
    probe("transp", 105, 52, 1'b1);
    probe("left_out", 99, 52, 1'b1);
    probe("bottom_out", 110, 70, 1'b1);

    // CharX change without frame_tick must not move the sprite
    CharX = 10'd300;
    probe("no_tear", 119, 52, 1'b1);
    CharX = 10'd100;

    // Random probes around the box
    for (int i = 0; i < 24; i++) begin
      x = 100 + $urandom_range(0, W + 5) - 3;
      y = 50 + $urandom_range(0, H + 5) - 3;
      probe("rand0", x, y, $urandom_range(0, 7) != 0);
    end

    // Position near the right/bottom edge: box must not wrap
    CharX = 10'($urandom_range(1008, 1023));
    CharY = 10'($urandom_range(1008, 1023));
    pulse_tick("latch_edge");
    probe("edge_wrap", 5, int'(CharY), 1'b1);
    for (int i = 0; i < 8; i++)
      probe("edge_rand", $urandom_range(1000, 1023), $urandom_range(1000, 1023), 1'b1);
    CharX = 10'd100; CharY = 10'd50;
    pulse_tick("latch_back");

    // Loop animation: 32 ticks
    do_start(1'b0);
    for (int i = 0; i < 32; i++) begin
      pulse_tick("loop");
      if (i == 11 || i == 19) begin
        for (int k = 0; k < 3; k++)
          probe("anim", 100 + $urandom_range(0, W - 1), 50 + $urandom_range(0, H - 1), 1'b1);
      end
    end

    // Stop freezes mid-play
    for (int i = 0; i < 10; i++) pulse_tick("pre_stop");
    do_stop();
    for (int i = 0; i < 8; i++) pulse_tick("frozen");

    // start+stop together: stays IDLE, frame unchanged
    start = 1'b1; stop = 1'b1;
    tick_clk();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", {31'd0, busy}, 32'd0);
    check("startstop_frame", {30'd0, anim_frame}, 32'(m_frame));

    // start together with frame_tick: restart, no step
    do_start(1'b0);
    for (int i = 0; i < 17; i++) pulse_tick("pre_restart");
    start = 1'b1; frame_tick = 1'b1;
    tick_clk();
    start = 1'b0; frame_tick = 1'b0;
    m_ticks = 0; m_frame = 0; m_play = 1'b1; m_oneshot = 1'b0;
    check("restart_frame", {30'd0, anim_frame}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) pulse_tick("post_restart");

    // Oneshot: 24 ticks then more
    do_start(1'b1);
    for (int i = 0; i < 24 + int'($urandom_range(4, 12)); i++) pulse_tick("oneshot");
    check("oneshot_end_frame", {30'd0, anim_frame}, 32'd3);
    check("oneshot_end_busy", {31'd0, busy}, 32'd0);
    probe("done_pix", 110, 60, 1'b1);

`ifdef SPRITE_FLIP_EN
    flip_h = 1'b1;
    DrawX = 10'd100; DrawY = 10'd50;
    #1;
    check("flip_addr", 32'(mem_if.rom_addr), 32'(m_frame * W * H + 19));
    flip_h = 1'b0;
`endif

    // Asynchronous reset mid-PLAY with an opaque pixel showing
    do_start(1'b0);
    for (int i = 0; i < 9; i++) pulse_tick("pre_reset");
    rom[m_frame * W * H + 45] = 4'd7;
    probe("pre_reset_pix", 105, 52, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset rgb=%03h active=%0d frame=%0d busy=%0d",
             {red_out, green_out, blue_out}, active, anim_frame, busy);
    check("arst_rgb", {20'd0, red_out, green_out, blue_out}, 32'd0);
    check("arst_active", {31'd0, active}, 32'd0);
    check("arst_frame", {30'd0, anim_frame}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    m_px = 0; m_py = 0; m_frame = 0; m_ticks = 0; m_play = 1'b0; m_oneshot = 1'b0;
    tick_clk();
    reset_n = 1'b1;
    tick_clk();
    probe("post_reset", 5, 5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
